// File: rtl/mixer_gain_sequencer_if.sv
// ---------------------------------------------------------------------------
// mixer_gain_sequencer_if
//   Cartridge-bus I/O port pair used to program the mixer gains.
//   master : bus side (CPU / testbench) drives strobes, address, write data
//   slave  : mixer side, returns readback data and its drive-enable
// Signals
//   n_ioreq, n_wr, n_rd : active-low bus strobes, asynchronous to clk
//   address [7:0]       : I/O address
//   wdata   [7:0]       : write data
//   rdata   [7:0]       : readback data
//   rdata_en            : drive-enable for rdata
// ---------------------------------------------------------------------------
interface mixer_gain_sequencer_if;
  logic       n_ioreq;
  logic       n_wr;
  logic       n_rd;
  logic [7:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_en;

  modport master (
    output n_ioreq, n_wr, n_rd, address, wdata,
    input  rdata, rdata_en
  );

  modport slave (
    input  n_ioreq, n_wr, n_rd, address, wdata,
    output rdata, rdata_en
  );
endinterface

// File: rtl/mixer_gain_sequencer.sv
// ---------------------------------------------------------------------------
// mixer_gain_sequencer
//   Time-multiplexed 4-source mixer (SCC, OPLL, SSG, DCSG) with a 5-bit gain
//   per source (16 = unity). A single shared multiplier is stepped through
//   the four channels once per sample_en; the 23-bit sum is scaled by 1/16
//   and saturated to 17 bits signed.
// Ports
//   clk, reset  : system clock; asynchronous active-high reset
//   sample_en   : one-clk strobe that starts a mix sequence (ignored while busy)
//   bus         : I/O index/data port pair (slave modport)
//   scc_in      : 11-bit signed     opll_in : 16-bit signed
//   ssg_in      : 8-bit unsigned    dcsg_in : 14-bit signed
//   mix_out     : 17-bit signed saturated mix, held between updates
//   mix_valid   : one-clk pulse when mix_out has just been updated
//   busy        : high while the four channel steps run
// Configuration
//   MIXER_GAIN_READBACK_EN : when defined, an IN from IO_DATA_ADDR returns
//   {3'b000, gain[index]}; otherwise rdata/rdata_en are tied off.
// ---------------------------------------------------------------------------
module mixer_gain_sequencer #(
  parameter logic [7:0] IO_INDEX_ADDR = 8'h3E,
  parameter logic [7:0] IO_DATA_ADDR  = 8'h3F,
  parameter logic [4:0] DEFAULT_GAIN  = 5'd16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  mixer_gain_sequencer_if.slave bus,
  input  logic signed [10:0]  scc_in,
  input  logic signed [15:0]  opll_in,
  input  logic        [7:0]   ssg_in,
  input  logic signed [13:0]  dcsg_in,
  output logic signed [16:0]  mix_out,
  output logic                mix_valid,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_CH0, S_CH1, S_CH2, S_CH3, S_OUT} state_t;

  state_t state, next_state;
  logic   start;
  logic [1:0] sel;

  // ---------------- bus write path ----------------
  logic [1:0] wr_sync;
  logic       wr_prev;
  logic       wr_rise;
  logic [4:0] gain [4];
  logic [1:0] index;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync <= 2'b00;
      wr_prev <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[0], ~bus.n_ioreq & ~bus.n_wr};
      wr_prev <= wr_sync[1];
    end
  end

  assign wr_rise = wr_sync[1] & ~wr_prev;

  // NOTE: the gain registers are a tiny register file, not a RAM, and must
  // come up at unity, so they are explicitly reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) gain[i] <= DEFAULT_GAIN;
      index <= 2'd0;
    end else if (wr_rise) begin
      if (bus.address == IO_INDEX_ADDR) begin
        index <= bus.wdata[1:0];
      end else if (bus.address == IO_DATA_ADDR) begin
        gain[index] <= bus.wdata[4:0];
        index       <= index + 2'd1;
      end
    end
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // busy and mix_valid are decoded from the state register, so mix_valid is
  // high during OUT (five clocks after the accepted strobe) while mix_out was
  // loaded on the CH3->OUT edge. OUT accepts a new strobe like IDLE does,
  // since busy is already low there.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    busy       = 1'b0;
    mix_valid  = 1'b0;
    sel        = 2'd0;
    case (state)
      S_IDLE: if (sample_en) begin
        start      = 1'b1;
        next_state = S_CH0;
      end
      S_CH0: begin busy = 1'b1; sel = 2'd0; next_state = S_CH1; end
      S_CH1: begin busy = 1'b1; sel = 2'd1; next_state = S_CH2; end
      S_CH2: begin busy = 1'b1; sel = 2'd2; next_state = S_CH3; end
      S_CH3: begin busy = 1'b1; sel = 2'd3; next_state = S_OUT; end
      S_OUT: begin
        mix_valid = 1'b1;
        if (sample_en) begin
          start      = 1'b1;
          next_state = S_CH0;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Align every source to a common 16-bit signed full scale.
  logic signed [15:0] ch_aligned [4];
  assign ch_aligned[0] = {scc_in, 5'd0};
  assign ch_aligned[1] = opll_in;
  assign ch_aligned[2] = {3'b000, ssg_in, 5'd0};
  assign ch_aligned[3] = {dcsg_in, 2'b00};

  logic signed [15:0] ch_snap   [4];
  logic        [4:0]  gain_snap [4];
  logic signed [22:0] acc, acc_next;
  logic signed [15:0] ch_sel;
  logic signed [5:0]  gain_sel;
  logic signed [20:0] prod;
  logic signed [18:0] scaled;
  logic signed [16:0] sat_next;

  // The single shared multiplier: one channel per clock.
  assign ch_sel   = ch_snap[sel];
  assign gain_sel = $signed({1'b0, gain_snap[sel]});
  assign prod     = 21'(ch_sel) * 21'(gain_sel);
  assign acc_next = acc + 23'(prod);
  assign scaled   = acc_next[22:4];   // arithmetic >>>4 of the final sum

  always_comb begin
    sat_next = scaled[16:0];
    if (scaled > 19'sd65535)       sat_next = 17'h0_FFFF;
    else if (scaled < -19'sd65536) sat_next = 17'h1_0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ch_snap[i]   <= '0;
        gain_snap[i] <= '0;
      end
      acc     <= '0;
      mix_out <= '0;
    end else if (start) begin
      // Snapshot uses the pre-write gains if a bus write lands this clock.
      for (int i = 0; i < 4; i++) begin
        ch_snap[i]   <= ch_aligned[i];
        gain_snap[i] <= gain[i];
      end
      acc <= '0;
    end else if (busy) begin
      acc <= acc_next;
      if (state == S_CH3) mix_out <= sat_next;
    end
  end

  // ---------------- optional readback ----------------
`ifdef MIXER_GAIN_READBACK_EN
  logic [1:0] rd_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sync      <= 2'b00;
      bus.rdata    <= 8'h00;
      bus.rdata_en <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[0], ~bus.n_ioreq & ~bus.n_rd};
      if (rd_sync[1] && bus.address == IO_DATA_ADDR) begin
        bus.rdata    <= {3'b000, gain[index]};
        bus.rdata_en <= 1'b1;
      end else begin
        bus.rdata    <= 8'h00;
        bus.rdata_en <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.wdata[7:5]};
`else
  assign bus.rdata    = 8'h00;
  assign bus.rdata_en = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.wdata[7:5], bus.n_rd};
`endif

endmodule

// File: tb/tb_mixer_gain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mixer_gain_sequencer
//   Self-checking bench for mixer_gain_sequencer. Expected mixes come from a
//   plain-arithmetic model: sum of scaled sources times gain, floor-divided
//   by 16, clamped to 17-bit signed. Gain/index state is tracked per bus
//   write in the bench.
// ---------------------------------------------------------------------------
module tb_mixer_gain_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_en;
  logic signed [10:0] scc_in;
  logic signed [15:0] opll_in;
  logic        [7:0]  ssg_in;
  logic signed [13:0] dcsg_in;
  logic signed [16:0] mix_out;
  logic               mix_valid;
  logic               busy;

  always #5 clk = ~clk;

  mixer_gain_sequencer_if bus_if ();

  mixer_gain_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .bus       (bus_if),
    .scc_in    (scc_in),
    .opll_in   (opll_in),
    .ssg_in    (ssg_in),
    .dcsg_in   (dcsg_in),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .busy      (busy)
  );

  int checks = 0;
  int passed = 0;
  int model_gain [4];
  int model_index;

  // Reference: every source scaled to 16-bit full scale, weighted by gain/16.
  function automatic int model_mix(input int scc, input int opll, input int ssg,
                                   input int dcsg, input int g0, input int g1,
                                   input int g2, input int g3);
    longint sum, q;
    sum = longint'(scc) * 32 * g0 + longint'(opll) * g1
        + longint'(ssg) * 32 * g2 + longint'(dcsg) * 4 * g3;
    q = sum / 16;
    if (sum < 0 && (sum % 16) != 0) q = q - 1;   // floor division
    if (q > 65535)  q = 65535;
    if (q < -65536) q = -65536;
    return int'(q);
  endfunction

  function automatic int expect_now(input int scc, input int opll, input int ssg,
                                    input int dcsg);
    return model_mix(scc, opll, ssg, dcsg, model_gain[0], model_gain[1],
                     model_gain[2], model_gain[3]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_gain[i] = 16;
    model_index = 0;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    bus_if.address = addr;
    bus_if.wdata   = data;
    bus_if.n_ioreq = 1'b0;
    bus_if.n_wr    = 1'b0;
    repeat (4) tick();
    bus_if.n_ioreq = 1'b1;
    bus_if.n_wr    = 1'b1;
    repeat (4) tick();
    if (addr == 8'h3E) begin
      model_index = int'(data[1:0]);
    end else if (addr == 8'h3F) begin
      model_gain[model_index] = int'(data[4:0]);
      model_index = (model_index + 1) % 4;
    end
  endtask

  task automatic drive_sources(input int s, input int o, input int g, input int d);
    scc_in  = 11'(s);
    opll_in = 16'(o);
    ssg_in  = 8'(g);
    dcsg_in = 14'(d);
  endtask

  // Pulse sample_en and wait (bounded) for mix_valid; returns mix_out.
  task automatic do_sample(input int s, input int o, input int g, input int d,
                           output int got);
    int lat;
    drive_sources(s, o, g, d);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    lat = 1;
    while (!mix_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      $display("FAIL sample_timeout: mix_valid not seen within %0d clocks", lat);
    end
    got = int'(mix_out);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_en = 1'b0;
    drive_sources(0, 0, 0, 0);
    bus_if.n_ioreq = 1'b1;
    bus_if.n_wr    = 1'b1;
    bus_if.n_rd    = 1'b1;
    bus_if.address = 8'h00;
    bus_if.wdata   = 8'h00;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({mix_out, mix_valid, busy, bus_if.rdata, bus_if.rdata_en} !== 28'd0)
      $display("FAIL reset_state: mix_out=%0d valid=%b busy=%b rdata=%h rdata_en=%b, want all 0",
               mix_out, mix_valid, busy, bus_if.rdata, bus_if.rdata_en);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int exp_mix;
    drive_sources(256, 0, 0, 0);
    exp_mix = expect_now(256, 0, 0, 0);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (c <= 4) begin
        if (busy !== 1'b1 || mix_valid !== 1'b0)
          $display("FAIL latency_busy T+%0d: busy=%b valid=%b, want busy=1 valid=0", c, busy, mix_valid);
        else passed++;
      end else if (c == 5) begin
        if (mix_valid !== 1'b1 || busy !== 1'b0 || int'(mix_out) != exp_mix)
          $display("FAIL latency_out T+5: valid=%b busy=%b mix_out=%0d, want 1 0 %0d",
                   mix_valid, busy, mix_out, exp_mix);
        else passed++;
      end else begin
        if (mix_valid !== 1'b0 || int'(mix_out) != exp_mix)
          $display("FAIL latency_hold T+6: valid=%b mix_out=%0d, want 0 %0d", mix_valid, mix_out, exp_mix);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int got, exp_mix;
    exp_mix = expect_now(1023, 32767, 255, 8191);
    do_sample(1023, 32767, 255, 8191, got);
    checks++;
    if (got != exp_mix || got != 65535)
      $display("FAIL sat_pos: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
    exp_mix = expect_now(-1024, -32768, 0, -8192);
    do_sample(-1024, -32768, 0, -8192, got);
    checks++;
    if (got != exp_mix || got != -65536)
      $display("FAIL sat_neg: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
  endtask

  task automatic test_gain_write();
    int got, exp_mix;
    io_write(8'h3E, 8'h01);
    io_write(8'h3F, 8'h08);
    exp_mix = expect_now(0, 1000, 0, 0);
    do_sample(0, 1000, 0, 0, got);
    checks++;
    if (got != exp_mix || got != 500)
      $display("FAIL gain_opll_half: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
    io_write(8'h3F, 8'hE0);   // auto-incremented index 2, upper bits ignored
    exp_mix = expect_now(0, 1000, 255, 0);
    do_sample(0, 1000, 255, 0, got);
    checks++;
    if (got != exp_mix || got != 500)
      $display("FAIL gain_ssg_mute: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int pulses, first_at, exp_mix;
    drive_sources(-300, 1234, 77, -999);
    exp_mix = expect_now(-300, 1234, 77, -999);
    pulses = 0;
    first_at = 0;
    sample_en = 1'b1;
    tick();
    for (int c = 1; c <= 14; c++) begin
      sample_en = (c == 2);
      if (mix_valid) begin
        pulses++;
        if (first_at == 0) first_at = c;
      end
      tick();
    end
    sample_en = 1'b0;
    checks++;
    if (pulses != 1 || first_at != 5)
      $display("FAIL busy_ignore: pulses=%0d first_at=T+%0d, want 1 at T+5", pulses, first_at);
    else passed++;
    checks++;
    if (int'(mix_out) != exp_mix)
      $display("FAIL busy_ignore_value: mix_out=%0d, want %0d", mix_out, exp_mix);
    else passed++;
  endtask

  task automatic test_gain_during_sequence();
    int got, lat, exp_old, exp_new;
    io_write(8'h3E, 8'h01);
    exp_old = expect_now(0, 1000, 0, 0);
    drive_sources(0, 1000, 0, 0);
    bus_if.address = 8'h3F;
    bus_if.wdata   = 8'h04;
    bus_if.n_ioreq = 1'b0;
    bus_if.n_wr    = 1'b0;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    lat = 1;
    while (!mix_valid && lat < 20) begin
      if (lat == 4) begin
        bus_if.n_ioreq = 1'b1;
        bus_if.n_wr    = 1'b1;
      end
      tick();
      lat++;
    end
    got = int'(mix_out);
    bus_if.n_ioreq = 1'b1;
    bus_if.n_wr    = 1'b1;
    repeat (4) tick();
    model_gain[model_index] = 4;
    model_index = (model_index + 1) % 4;
    checks++;
    if (got != exp_old || lat != 5)
      $display("FAIL gain_mid_seq_old: mix_out=%0d at T+%0d, want %0d at T+5", got, lat, exp_old);
    else passed++;
    exp_new = expect_now(0, 1000, 0, 0);
    do_sample(0, 1000, 0, 0, got);
    checks++;
    if (got != exp_new || got != 250)
      $display("FAIL gain_mid_seq_new: mix_out=%0d, want %0d", got, exp_new);
    else passed++;
  endtask

  task automatic test_random();
    int got, exp_mix, s, o, g, d;
    logic [31:0] r;
    for (int it = 0; it < 16; it++) begin
      if (it % 4 == 0) begin
        r = $urandom();
        io_write(8'h3E, {r[7:2], 2'b00});
        for (int k = 0; k < 4; k++) begin
          r = $urandom();
          io_write(8'h3F, r[7:0]);
        end
      end
      s = int'($urandom_range(2047)) - 1024;
      o = int'($urandom_range(65535)) - 32768;
      g = int'($urandom_range(255));
      d = int'($urandom_range(16383)) - 8192;
      exp_mix = expect_now(s, o, g, d);
      do_sample(s, o, g, d, got);
      checks++;
      if (got != exp_mix)
        $display("FAIL random_mix[%0d]: mix_out=%0d, want %0d (scc=%0d opll=%0d ssg=%0d dcsg=%0d)",
                 it, got, exp_mix, s, o, g, d);
      else passed++;
    end
  endtask

  task automatic test_readback();
    int got, exp_mix;
    io_write(8'h3E, 8'h02);
    io_write(8'h3F, 8'h05);
    io_write(8'h3E, 8'h02);
    bus_if.address = 8'h3F;
    bus_if.n_ioreq = 1'b0;
    bus_if.n_rd    = 1'b0;
    repeat (4) tick();
    checks++;
`ifdef MIXER_GAIN_READBACK_EN
    if (bus_if.rdata !== 8'h05 || bus_if.rdata_en !== 1'b1)
      $display("FAIL readback: rdata=%h rdata_en=%b, want 05 1", bus_if.rdata, bus_if.rdata_en);
    else passed++;
`else
    if (bus_if.rdata !== 8'h00 || bus_if.rdata_en !== 1'b0)
      $display("FAIL readback_off: rdata=%h rdata_en=%b, want 00 0", bus_if.rdata, bus_if.rdata_en);
    else passed++;
`endif
    bus_if.n_ioreq = 1'b1;
    bus_if.n_rd    = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus_if.rdata_en !== 1'b0)
      $display("FAIL readback_release: rdata_en=%b, want 0", bus_if.rdata_en);
    else passed++;
    // A read must not advance the index: this write lands in gain[2].
    io_write(8'h3F, 8'h07);
    exp_mix = expect_now(0, 0, 255, 0);
    do_sample(0, 0, 255, 0, got);
    checks++;
    if (got != exp_mix || got != 3570)
      $display("FAIL read_keeps_index: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int pulses, got, exp_mix;
    io_write(8'h3E, 8'h00);
    io_write(8'h3F, 8'h03);
    drive_sources(256, 0, 0, 0);
    pulses = 0;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mix_out !== 17'sd0 || mix_valid !== 1'b0)
      $display("FAIL abort_reset_values: busy=%b mix_out=%0d valid=%b, want 0 0 0", busy, mix_out, mix_valid);
    else passed++;
    repeat (2) begin
      tick();
      if (mix_valid) pulses++;
    end
    reset = 1'b0;
    model_reset();
    repeat (8) begin
      tick();
      if (mix_valid) pulses++;
    end
    checks++;
    if (pulses != 0)
      $display("FAIL abort_no_valid: pulses=%0d, want 0", pulses);
    else passed++;
    exp_mix = expect_now(256, 0, 0, 0);
    do_sample(256, 0, 0, 0, got);
    checks++;
    if (got != exp_mix || got != 8192)
      $display("FAIL abort_gain_default: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
    // Index must be back at 0: a bare data write hits the SCC gain.
    io_write(8'h3F, 8'h08);
    exp_mix = expect_now(256, 0, 0, 0);
    do_sample(256, 0, 0, 0, got);
    checks++;
    if (got != exp_mix || got != 4096)
      $display("FAIL abort_index_default: mix_out=%0d, want %0d", got, exp_mix);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_gain_write();
    test_busy_ignore();
    test_gain_during_sequence();
    test_random();
    test_readback();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
